// File: rtl/dnn_batch_sched.sv
// Batch sequencer for the fix8 ReLU inference engine: steps test cases,
// scores each result by signed argmax against the expected label.
module dnn_batch_sched #(
    parameter int NUM_TC  = 5000,
    parameter int N_OUT   = 10,
    parameter int OUT_W   = 8,
    parameter int LBL_W   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run_start,
    input  logic                   run_abort,
    output logic                   next_tc,
    output logic                   dnn_start,
    output logic                   dnn_reset,
    input  logic                   dnn_done,
    input  logic [N_OUT*OUT_W-1:0] dnn_out,
    input  logic [LBL_W-1:0]       exp_y,
    output logic [LBL_W-1:0]       pred_idx,
    output logic                   pred_vld,
    output logic [CNT_W-1:0]       tc_count,
    output logic [CNT_W-1:0]       hit_count,
    output logic                   busy,
    output logic                   run_done,
    output logic                   err_tmo
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NEXT   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_ARGMAX = 3'd4;
    localparam logic [2:0] S_SCORE  = 3'd5;
    localparam logic [2:0] S_CLEAR  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam int AI_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]              state;
    logic                    done_q;
    logic                    rst_pulse;
    logic [31:0]             wcnt;
    logic [AI_W-1:0]         ai;
    logic signed [OUT_W-1:0] amax;
    logic [LBL_W-1:0]        aidx;
    logic signed [OUT_W-1:0] outs [N_OUT];
    logic signed [OUT_W-1:0] elem;
    logic                    done_edge;
    logic                    tmo_hit;
    logic                    last_el;

    for (genvar g = 0; g < N_OUT; g++) begin : g_unpack
        assign outs[g] = dnn_out[g*OUT_W +: OUT_W];
    end

    assign elem      = outs[ai];
    assign done_edge = dnn_done & ~done_q;
    assign tmo_hit   = (TIMEOUT != 0) && (wcnt == 32'(TIMEOUT));
    assign last_el   = (ai == AI_W'(N_OUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            done_q    <= 1'b0;
            rst_pulse <= 1'b0;
            wcnt      <= '0;
            ai        <= '0;
            amax      <= '0;
            aidx      <= '0;
            pred_idx  <= '0;
            pred_vld  <= 1'b0;
            tc_count  <= '0;
            hit_count <= '0;
            err_tmo   <= 1'b0;
        end else begin
            done_q    <= dnn_done;
            rst_pulse <= 1'b0;
            pred_vld  <= 1'b0;
            if (run_abort) begin
                // engine may be mid-computation; clear it on the way out
                if (state == S_WAIT || state == S_ARGMAX)
                    rst_pulse <= 1'b1;
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (run_start) begin
                            tc_count  <= '0;
                            hit_count <= '0;
                            err_tmo   <= 1'b0;
                            state     <= S_NEXT;
                        end
                    end
                    S_NEXT:  state <= S_START;
                    S_START: begin
                        wcnt  <= 32'd1;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (done_edge) begin
                            ai    <= '0;
                            amax  <= '0;
                            aidx  <= '0;
                            state <= S_ARGMAX;
                        end else if (tmo_hit) begin
                            err_tmo   <= 1'b1;
                            rst_pulse <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            wcnt <= wcnt + 32'd1;
                        end
                    end
                    S_ARGMAX: begin
                        // strict compare keeps the lowest index on ties
                        if (elem > amax) begin
                            amax <= elem;
                            aidx <= LBL_W'(ai) + LBL_W'(1);
                        end
                        ai <= last_el ? '0 : ai + 1'b1;
                        if (last_el)
                            state <= S_SCORE;
                    end
                    S_SCORE: begin
                        pred_idx <= aidx;
                        pred_vld <= 1'b1;
                        if (tc_count != CNT_MAX)
                            tc_count <= tc_count + 1'b1;
                        if (aidx == exp_y && hit_count != CNT_MAX)
                            hit_count <= hit_count + 1'b1;
                        state <= S_CLEAR;
                    end
                    S_CLEAR: begin
                        state <= (tc_count == CNT_W'(NUM_TC)) ? S_DONE : S_NEXT;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign next_tc   = (state == S_NEXT);
    assign dnn_start = (state == S_START);
    assign dnn_reset = (state == S_CLEAR) | rst_pulse;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign run_done  = (state == S_DONE);

endmodule

// File: tb/tb_dnn_batch_sched.sv
// Directed bench for dnn_batch_sched: argmax vector table plus
// hand sequences for held done, abort, timeout and async reset.
module tb_dnn_batch_sched;

    localparam int NT  = 3;
    localparam int NO  = 10;
    localparam int OW  = 8;
    localparam int LW  = 8;
    localparam int CW  = 16;
    localparam int TMO = 20;
    localparam int DLY = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run_start = 1'b0;
    logic             run_abort = 1'b0;
    logic             next_tc, dnn_start, dnn_reset, dnn_done;
    logic [NO*OW-1:0] dnn_out = '0;
    logic [LW-1:0]    exp_y = '0;
    logic [LW-1:0]    pred_idx;
    logic             pred_vld;
    logic [CW-1:0]    tc_count, hit_count;
    logic             busy, run_done, err_tmo;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dnn_batch_sched #(
        .NUM_TC(NT), .N_OUT(NO), .OUT_W(OW),
        .LBL_W(LW), .CNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .run_start(run_start), .run_abort(run_abort),
        .next_tc(next_tc), .dnn_start(dnn_start),
        .dnn_reset(dnn_reset), .dnn_done(dnn_done),
        .dnn_out(dnn_out), .exp_y(exp_y),
        .pred_idx(pred_idx), .pred_vld(pred_vld),
        .tc_count(tc_count), .hit_count(hit_count),
        .busy(busy), .run_done(run_done), .err_tmo(err_tmo)
    );

    // engine model: done rises DLY cycles after start, clears on dnn_reset
    logic manual = 1'b0;
    logic man_done = 1'b0;
    logic eng_done = 1'b0;
    int   dcnt = 0;

    always @(posedge clk) begin
        if (!rst_n || dnn_reset) begin
            eng_done <= 1'b0;
            dcnt     <= 0;
        end else if (dnn_start) begin
            dcnt <= DLY;
        end else if (dcnt == 1) begin
            eng_done <= 1'b1;
            dcnt     <= 0;
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
        end
    end

    assign dnn_done = manual ? man_done : eng_done;

    typedef struct {
        int fill;
        int k1;
        int v1;
        int k2;
        int v2;
        int ey;
        int pred;
        int hits;
    } vec_t;

    vec_t vt [5];

    function automatic logic [NO*OW-1:0] mk(input vec_t v);
        logic [NO*OW-1:0] r;
        for (int i = 0; i < NO; i++) r[i*OW +: OW] = OW'(v.fill);
        if (v.k1 >= 0) r[v.k1*OW +: OW] = OW'(v.v1);
        if (v.k2 >= 0) r[v.k2*OW +: OW] = OW'(v.v2);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        check({nm, "_ctl"}, 32'({next_tc, dnn_start, dnn_reset, pred_vld,
                                 busy, run_done, err_tmo}), 0);
        check({nm, "_pred"}, 32'(pred_idx), 0);
        check({nm, "_cnt"}, {tc_count, hit_count}, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (dnn_start) ok = 1'b1;
        end
        check({nm, "_start_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_done(input string nm);
        bit fin = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            if (run_done) fin = 1'b1;
        end
        check({nm, "_finish"}, 32'(fin), 1);
    endtask

    task automatic do_run(input int ep, input string nm);
        int seen = 0;
        bit fin = 1'b0;
        pulse_start();
        check({nm, "_next_tc"}, 32'(next_tc), 1);
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            if (pred_vld) begin
                seen++;
                check({nm, "_pred"}, 32'(pred_idx), 32'(ep));
            end
            if (run_done) fin = 1'b1;
        end
        check({nm, "_finish"}, 32'(fin), 1);
        check({nm, "_nvld"}, 32'(seen), NT);
    endtask

    initial begin
        int early;
        int lat;
        bit got;
        bit ok;

        vt[0] = '{10, 4, 90, 6, -100, 5, 5, 3};
        vt[1] = '{-3, -1, 0, -1, 0, 0, 0, 3};
        vt[2] = '{0, 2, 127, 7, 127, 5, 3, 0};
        vt[3] = '{0, 9, 1, -1, 0, 10, 10, 3};
        vt[4] = '{-128, 1, 5, 3, 6, 4, 4, 3};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            dnn_out = mk(vt[v]);
            exp_y = LW'(vt[v].ey);
            do_run(vt[v].pred, nm);
            check({nm, "_tc"}, 32'(tc_count), NT);
            check({nm, "_hits"}, 32'(hit_count), 32'(vt[v].hits));
            check({nm, "_busy"}, 32'(busy), 0);
        end

        // done already high when WAIT is entered is not an edge
        dnn_out = mk(vt[0]);
        exp_y = 8'd5;
        manual = 1'b1;
        man_done = 1'b1;
        pulse_start();
        wait_start("held");
        early = 0;
        repeat (8) begin
            @(negedge clk);
            if (pred_vld) early++;
        end
        check("held_no_early", 32'(early), 0);
        check("held_tc", 32'(tc_count), 0);
        check("held_busy", 32'(busy), 1);
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        man_done = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (pred_vld) got = 1'b1;
        end
        check("fresh_edge_lat", 32'(lat), NO + 2);
        check("fresh_edge_pred", 32'(pred_idx), 5);
        manual = 1'b0;
        wait_done("held");
        check("held_tc_end", 32'(tc_count), NT);
        check("held_hits_end", 32'(hit_count), NT);

        // abort during ARGMAX of the third test case
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (tc_count == 16'd2) ok = 1'b1;
        end
        check("abort_reach2", 32'(ok), 1);
        wait_start("abort");
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (dnn_done) ok = 1'b1;
        end
        check("abort_done_seen", 32'(ok), 1);
        repeat (2) @(negedge clk);
        run_abort = 1'b1;
        @(negedge clk);
        run_abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_run_done", 32'(run_done), 0);
        check("abort_rst_pulse", 32'(dnn_reset), 1);
        check("abort_tc", 32'(tc_count), 2);
        check("abort_hits", 32'(hit_count), 2);
        check("abort_no_vld", 32'(pred_vld), 0);
        @(negedge clk);
        check("abort_rst_single", 32'(dnn_reset), 0);
        pulse_start();
        check("restart_cnt", {tc_count, hit_count}, 0);
        check("restart_next", 32'(next_tc), 1);
        wait_done("restart");
        check("restart_tc", 32'(tc_count), NT);

        // timeout: done never rises
        manual = 1'b1;
        man_done = 1'b0;
        pulse_start();
        wait_start("tmo");
        repeat (TMO) @(negedge clk);
        check("tmo_not_yet", 32'(err_tmo), 0);
        check("tmo_busy", 32'(busy), 1);
        @(negedge clk);
        check("tmo_err", 32'(err_tmo), 1);
        check("tmo_rst_pulse", 32'(dnn_reset), 1);
        check("tmo_run_done", 32'(run_done), 1);
        check("tmo_tc", 32'(tc_count), 0);
        @(negedge clk);
        check("tmo_rst_single", 32'(dnn_reset), 0);
        check("tmo_sticky", 32'(err_tmo), 1);

        // async reset in the middle of WAIT
        pulse_start();
        check("start_clr_err", 32'(err_tmo), 0);
        wait_start("arst");
        repeat (2) @(negedge clk);
        check("arst_pre_busy", 32'(busy), 1);
        check("arst_pre_pred", 32'(pred_idx), 5);
        #2 rst_n = 1'b0;
        #1 chk_zero("arst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        early = 0;
        repeat (10) begin
            @(negedge clk);
            if (next_tc || dnn_start || busy) early++;
        end
        check("arst_quiet", 32'(early), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
